// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the init command ROM for the
// HD44780 refresh engine and its bus writer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY      = 8'h06;
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;
  localparam logic [7:0] SPACE      = 8'h20;

  localparam logic [2:0] INIT_LAST = 3'd4;
  localparam int         GAP_W     = 8;

  typedef enum logic [1:0] {
    ST_PWR   = 2'd0,
    ST_INIT  = 2'd1,
    ST_LINE1 = 2'd2,
    ST_LINE2 = 2'd3
  } lcd_state_e;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_SETUP = 3'd1,
    W_EN_HI = 3'd2,
    W_EN_LO = 3'd3,
    W_GAP   = 3'd4
  } wr_state_e;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return FUNC_SET;
      3'd1:    return FUNC_SET;
      3'd2:    return DISP_ON;
      3'd3:    return CLEAR;
      default: return ENTRY;
    endcase
  endfunction

  // Control codes have no glyph on the panel, so they are shown as blanks.
  function automatic logic [7:0] map_char(input logic [7:0] b);
    return (b < SPACE) ? SPACE : b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 write cycle: SETUP, EN_HI, EN_LO, then gap_len GAP cycles.
// Handshake: start_i is taken when idle or while done_o is high (last GAP
// cycle), so transactions chain with no dead cycle; rs_i/data_i must stay
// valid through the SETUP cycle, where they pass straight to the bus and
// are captured at its end.
module lcd_bus_writer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             rs_i,
  input  logic [7:0]       data_i,
  input  logic [GAP_W-1:0] gap_len_i,
  output logic             en_o,
  output logic             rs_o,
  output logic [7:0]       data_o,
  output logic             done_o,
  output logic [2:0]       state_o
);

  wr_state_e        state_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic [GAP_W-1:0] gap_len_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             accept;

  assign done_o  = (state_q == W_GAP) && (gap_cnt_q <= GAP_W'(1));
  assign accept  = start_i && ((state_q == W_IDLE) || done_o);
  assign en_o    = en_q;
  assign rs_o    = (state_q == W_SETUP) ? rs_i : rs_q;
  assign data_o  = (state_q == W_SETUP) ? data_i : data_q;
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_IDLE;
      en_q      <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (accept) begin
            state_q   <= W_SETUP;
            gap_len_q <= gap_len_i;
          end
        end
        W_SETUP: begin
          state_q <= W_EN_HI;
          en_q    <= 1'b1;
          rs_q    <= rs_i;
          data_q  <= data_i;
        end
        W_EN_HI: begin
          state_q <= W_EN_LO;
          en_q    <= 1'b0;
        end
        W_EN_LO: begin
          state_q   <= W_GAP;
          gap_cnt_q <= gap_len_q;
        end
        W_GAP: begin
          if (!done_o) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else if (accept) begin
            state_q   <= W_SETUP;
            gap_len_q <= gap_len_i;
          end else begin
            state_q <= W_IDLE;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_engine.sv
// Power-up wait, HD44780 init, then an endless refresh of the 32-byte
// character RAM onto a 16x2 panel through lcd_bus_writer.
module lcd_refresh_engine
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT = 30,
  parameter int CMD_WAIT = 1,
  parameter int CLR_WAIT = 4,
  parameter int ADDR_W   = 5
)(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  inout  wire  [7:0]        LCD_DATA,
  output logic              LCD_RW,
  output logic              LCD_EN,
  output logic              LCD_RS,
  output logic              init_done,
  output logic              frame_done,
  output logic [4:0]        dbg_state_o
);

  localparam logic [15:0]      PWR_LAST = 16'(PWR_WAIT - 1);
  localparam logic [GAP_W-1:0] CMD_GAP  = GAP_W'(CMD_WAIT);
  localparam logic [GAP_W-1:0] CLR_GAP  = GAP_W'(CLR_WAIT);

  lcd_state_e        state_q;
  logic [15:0]       pwr_cnt_q;
  logic [2:0]        idx_q;
  logic [4:0]        pos_q;
  logic              fetch_q;
  logic              char_q;
  logic [7:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              init_done_q;
  logic              frame_done_q;

  logic             wr_start;
  logic             wr_done;
  logic             load_cmd;
  logic [7:0]       next_cmd;
  logic [GAP_W-1:0] wr_gap;
  logic [7:0]       wr_data;
  logic [7:0]       bus_data;
  logic [2:0]       wr_state;

  // Commands start on the writer's last GAP cycle; characters start from FETCH.
  always_comb begin
    wr_start = 1'b0;
    load_cmd = 1'b0;
    next_cmd = cmd_q;
    case (state_q)
      ST_PWR: begin
        if (pwr_cnt_q == PWR_LAST) begin
          wr_start = 1'b1;
          load_cmd = 1'b1;
          next_cmd = init_rom(3'd0);
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          load_cmd = 1'b1;
          next_cmd = (idx_q == INIT_LAST) ? LINE1_ADDR : init_rom(idx_q + 3'd1);
        end
      end
      ST_LINE1, ST_LINE2: begin
        if (fetch_q) begin
          wr_start = 1'b1;
        end else if (wr_done && pos_q == 5'd16) begin
          wr_start = 1'b1;
          load_cmd = 1'b1;
          next_cmd = (state_q == ST_LINE1) ? LINE2_ADDR : LINE1_ADDR;
        end
      end
      default: ;
    endcase
    wr_gap  = (load_cmd && next_cmd == CLEAR) ? CLR_GAP : CMD_GAP;
    wr_data = char_q ? map_char(mem_rd_data) : cmd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PWR;
      pwr_cnt_q    <= '0;
      idx_q        <= '0;
      pos_q        <= '0;
      fetch_q      <= 1'b0;
      char_q       <= 1'b0;
      cmd_q        <= 8'h00;
      addr_q       <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (load_cmd) begin
        cmd_q  <= next_cmd;
        char_q <= 1'b0;
      end
      if (fetch_q) begin
        fetch_q <= 1'b0;
        char_q  <= 1'b1;
      end
      case (state_q)
        ST_PWR: begin
          if (pwr_cnt_q == PWR_LAST) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 16'd1;
          end
        end
        ST_INIT: begin
          if (wr_done) begin
            if (idx_q == INIT_LAST) begin
              state_q     <= ST_LINE1;
              pos_q       <= '0;
              init_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_LINE1, ST_LINE2: begin
          // pos_q counts finished writes on this line: 0 is the address command.
          if (wr_done) begin
            if (pos_q == 5'd16) begin
              pos_q <= '0;
              if (state_q == ST_LINE1) begin
                state_q <= ST_LINE2;
              end else begin
                state_q      <= ST_LINE1;
                frame_done_q <= 1'b1;
              end
            end else begin
              fetch_q <= 1'b1;
              addr_q  <= ADDR_W'({state_q == ST_LINE2, pos_q[3:0]});
              pos_q   <= pos_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_PWR;
      endcase
    end
  end

  lcd_bus_writer u_writer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (wr_start),
    .rs_i      (char_q),
    .data_i    (wr_data),
    .gap_len_i (wr_gap),
    .en_o      (LCD_EN),
    .rs_o      (LCD_RS),
    .data_o    (bus_data),
    .done_o    (wr_done),
    .state_o   (wr_state)
  );

  assign LCD_DATA    = bus_data;
  assign LCD_RW      = 1'b0;
  assign mem_rd_addr = addr_q;
  assign init_done   = init_done_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = {wr_state, state_q};

endmodule

// File: tb/tb_lcd_refresh_engine.sv
// Directed bench for lcd_refresh_engine: captures every byte latched on an
// EN falling edge and checks streams, timing and reset behaviour.
module tb_lcd_refresh_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'h00;
  wire  [7:0] lcd_data;
  logic       lcd_rw, lcd_en, lcd_rs, init_done, frame_done;
  logic [4:0] dbg_state;

  logic [7:0] ram [32];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         fall;
  } cap_t;
  cap_t cap_q[$];
  int   fd_q[$];
  logic prev_en = 1'b0;

  typedef struct {
    int         addr;
    logic [7:0] ram_byte;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[10];

  lcd_refresh_engine #(
    .PWR_WAIT (30),
    .CMD_WAIT (1),
    .CLR_WAIT (4),
    .ADDR_W   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .LCD_DATA    (lcd_data),
    .LCD_RW      (lcd_rw),
    .LCD_EN      (lcd_en),
    .LCD_RS      (lcd_rs),
    .init_done   (init_done),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // Clock/reset and the registered RAM read port.
  always #5 clk = ~clk;
  always @(posedge clk) mem_rd_data <= ram[mem_rd_addr];
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (prev_en && !lcd_en) cap_q.push_back('{rs: lcd_rs, data: lcd_data, fall: cyc});
    prev_en = lcd_en;
  end
  always @(negedge clk) if (frame_done) fd_q.push_back(cyc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("wait_cyc_timeout", 32'(cyc), 32'(n));
  endtask

  function automatic logic [8:0] cap_word(input int i);
    if (i < cap_q.size()) return {cap_q[i].rs, cap_q[i].data};
    return 9'h1FF;
  endfunction

  function automatic int cap_fall(input int i);
    if (i < cap_q.size()) return cap_q[i].fall;
    return -1;
  endfunction

  // Capture index of character ch in frame f: 5 init bytes, 34 bytes per frame.
  function automatic int cap_idx(input int f, input int ch);
    return 5 + 34 * f + ((ch < 16) ? 1 + ch : 2 + ch);
  endfunction

  task automatic check_init_stream(input string tag);
    logic [7:0] init_exp [5];
    init_exp = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_init_byte%0d", tag, i), 32'(cap_word(i)), {23'd0, 1'b0, init_exp[i]});
    check({tag, "_first_fall"}, 32'(cap_fall(0)), 32'd32);
    check({tag, "_gap_0c_01"}, 32'(cap_fall(3) - cap_fall(2)), 32'd4);
    check({tag, "_gap_01_06"}, 32'(cap_fall(4) - cap_fall(3)), 32'd7);
  endtask

  initial begin
    string      msg;
    logic [7:0] frame0 [32];
    logic       quiet_bad;

    vecs[0] = '{5,  8'h07, 8'h20};
    vecs[1] = '{6,  8'h7F, 8'h7F};
    vecs[2] = '{0,  8'h00, 8'h20};
    vecs[3] = '{1,  8'h1F, 8'h20};
    vecs[4] = '{2,  8'h20, 8'h20};
    vecs[5] = '{7,  8'h21, 8'h21};
    vecs[6] = '{15, 8'h41, 8'h41};
    vecs[7] = '{16, 8'h0A, 8'h20};
    vecs[8] = '{20, 8'h80, 8'h80};
    vecs[9] = '{31, 8'hFF, 8'hFF};

    msg = "ENTER CODE";
    for (int i = 0; i < 32; i++) begin
      ram[i]    = (i < msg.len()) ? msg[i] : 8'h20;
      frame0[i] = ram[i];
    end

    // Reset held for 5 cycles: everything at reset values.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {20'd0, lcd_en, lcd_rs, lcd_rw, init_done, frame_done, lcd_data},
          32'd0);
    check("rst_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    quiet_bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      wait_cyc(c);
      if (lcd_en || lcd_rs || lcd_data != 8'h00 || init_done || frame_done) quiet_bad = 1'b1;
    end
    check("pwr_quiet", 32'(quiet_bad), 32'd0);
    wait_cyc(30);
    check("first_setup", {23'd0, lcd_en, lcd_rs, lcd_data}, {23'd0, 1'b0, 1'b0, 8'h38});
    wait_cyc(31);
    check("first_en_hi", {23'd0, lcd_en, lcd_rs, lcd_data}, {23'd0, 1'b1, 1'b0, 8'h38});
    wait_cyc(52);
    check("init_done_low", 32'(init_done), 32'd0);
    wait_cyc(53);
    check("init_done_high", 32'(init_done), 32'd1);
    check("line1_setup", {23'd0, lcd_rs, lcd_data}, {23'd0, 1'b0, 8'h80});
    check("state_line1", 32'(dbg_state[1:0]), 32'd2);
    check_init_stream("pwrup");

    // Frame 0: "ENTER CODE" padded with spaces.
    wait_cyc(221);
    check("f0_line1_cmd", 32'(cap_word(5)), 32'h080);
    check("f0_line2_cmd", 32'(cap_word(22)), 32'h0C0);
    for (int ch = 0; ch < 32; ch++)
      check($sformatf("f0_char%0d", ch), 32'(cap_word(cap_idx(0, ch))), {23'd0, 1'b1, frame0[ch]});
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    for (int v = 0; v < 10; v++) ram[vecs[v].addr] = vecs[v].ram_byte;
    wait_cyc(222);
    check("frame_done_width", 32'(frame_done), 32'd0);
    check("fd_first_cycle", 32'((fd_q.size() > 0) ? fd_q[0] : -1), 32'd221);
    wait_cyc(224);
    check("addr_before_wrap", 32'(mem_rd_addr), 32'd31);
    wait_cyc(225);
    check("addr_after_wrap", 32'(mem_rd_addr), 32'd0);

    // Frame 1: table-driven mapping vectors.
    wait_cyc(389);
    check("frame_done_f1", 32'(frame_done), 32'd1);
    for (int v = 0; v < 10; v++)
      check($sformatf("vec%0d_addr%0d", v, vecs[v].addr),
            32'(cap_word(cap_idx(1, vecs[v].addr))), {23'd0, 1'b1, vecs[v].exp_byte});
    wait_cyc(390);
    check("fd_period", 32'((fd_q.size() > 1) ? fd_q[1] - fd_q[0] : -1), 32'd168);

    // Frame 2: rewrite byte 3 while char 10 is on the bus.
    wait_cyc(445);
    check("at_char10", {23'd0, lcd_en, 3'd0, mem_rd_addr}, {23'd0, 1'b1, 3'd0, 5'd10});
    ram[3] = 8'h41;

    // Frame 4: reset during char 20's EN pulse.
    wait_cyc(835);
    check("char20_en_hi", {23'd0, lcd_en, lcd_rs, lcd_data}, {23'd0, 1'b1, 1'b1, 8'h80});
    check("f2_char3_old", 32'(cap_word(cap_idx(2, 3))), 32'h145);
    check("f3_char3_new", 32'(cap_word(cap_idx(3, 3))), 32'h141);
    check("fd_period_f3", 32'((fd_q.size() > 3) ? fd_q[3] - fd_q[2] : -1), 32'd168);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_en", 32'(lcd_en), 32'd0);
    check("midrst_vals", {22'd0, lcd_rs, init_done, lcd_data}, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    wait_cyc(5);
    cap_q.delete();
    wait_cyc(29);
    check("rerun_quiet", {22'd0, lcd_en, init_done, lcd_data}, 32'd0);
    wait_cyc(31);
    check("rerun_en_hi", {23'd0, lcd_en, lcd_rs, lcd_data}, {23'd0, 1'b1, 1'b0, 8'h38});
    wait_cyc(52);
    check("rerun_init_low", 32'(init_done), 32'd0);
    wait_cyc(53);
    check("rerun_init_high", 32'(init_done), 32'd1);
    check_init_stream("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
